// File: rtl/offchip_rx_deframer.sv
// Receive deframer: parses SOF/LEN/payload/CSUM frames from the link stage and
// releases payload to the core only once the checksum verifies. Define
// OFFCHIP_RX_STATS_EN to enable the committed/discarded frame counters.
module offchip_rx_deframer #(
  parameter int         DEPTH    = 16,
  parameter int         MAX_LEN  = 8,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] err_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] DepthPtr = (AW+1)'(DEPTH);
  localparam logic [AW:0] PtrOne   = (AW+1)'(1);
  localparam logic [7:0]  MaxLen8  = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAY,
    CSUM
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [AW:0] r_wptr;
  logic [AW:0] r_cptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_used;
  logic        w_full;
  logic [8:0]  r_mem [DEPTH];
  logic [8:0]  w_rdEntry;
  logic [7:0]  r_rem;
  logic [7:0]  r_csum;
  logic        r_frameErr;
  logic [1:0]  r_errCode;

  logic        w_accept;
  logic        w_pop;
  logic        w_write;
  logic        w_loadLen;
  logic        w_commit;
  logic        w_rollback;
  logic        w_lenErr;

  assign w_used   = r_wptr - r_rptr;
  assign w_full   = (w_used == DepthPtr);
  // Only payload bytes occupy the FIFO, so only PAY can stall the link.
  assign in_ready = (r_state != PAY) || !w_full;
  assign w_accept = in_valid && in_ready;

  assign out_valid = (r_cptr != r_rptr);
  assign w_pop     = out_valid && out_ready;
  assign w_rdEntry = r_mem[r_rptr[AW-1:0]];
  assign out_data  = w_rdEntry[7:0];
  assign out_last  = w_rdEntry[8];

  assign frame_err = r_frameErr;
  assign err_code  = r_errCode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_write     = 1'b0;
    w_loadLen   = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_lenErr    = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_accept && (in_data == SOF_BYTE)) begin
          w_nextState = LEN;
        end
      end
      LEN: begin
        if (w_accept) begin
          if ((in_data != 8'd0) && (in_data <= MaxLen8)) begin
            w_loadLen   = 1'b1;
            w_nextState = PAY;
          end else begin
            w_lenErr    = 1'b1;
            w_nextState = HUNT;
          end
        end
      end
      PAY: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (r_rem == 8'd1) begin
            w_nextState = CSUM;
          end
        end
      end
      CSUM: begin
        if (w_accept) begin
          if (in_data == r_csum) begin
            w_commit = 1'b1;
          end else begin
            w_rollback = 1'b1;
          end
          w_nextState = HUNT;
        end
      end
      default: w_nextState = HUNT;
    endcase
  end

  // Payload storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr[AW-1:0]] <= {(r_rem == 8'd1), in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_cptr     <= '0;
      r_rptr     <= '0;
      r_rem      <= 8'd0;
      r_csum     <= 8'd0;
      r_frameErr <= 1'b0;
      r_errCode  <= 2'd0;
    end else begin
      r_frameErr <= w_lenErr || w_rollback;
      if (w_lenErr) begin
        r_errCode <= 2'd1;
      end else if (w_rollback) begin
        r_errCode <= 2'd2;
      end
      if (w_loadLen) begin
        r_rem  <= in_data;
        r_csum <= 8'd0;
      end
      if (w_write) begin
        r_wptr <= r_wptr + PtrOne;
        r_rem  <= r_rem - 8'd1;
        r_csum <= r_csum ^ in_data;
      end
      if (w_commit) begin
        r_cptr <= r_wptr;
      end
      if (w_rollback) begin
        r_wptr <= r_cptr;
      end
      // The read side runs independently of commit/rollback on the write side.
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
    end
  end

`ifdef OFFCHIP_RX_STATS_EN
  logic [15:0] r_okCnt;
  logic [15:0] r_errCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_okCnt  <= 16'd0;
      r_errCnt <= 16'd0;
    end else begin
      if (w_commit && (r_okCnt != 16'hFFFF)) begin
        r_okCnt <= r_okCnt + 16'd1;
      end
      if ((w_lenErr || w_rollback) && (r_errCnt != 16'hFFFF)) begin
        r_errCnt <= r_errCnt + 16'd1;
      end
    end
  end

  assign frame_ok_cnt = r_okCnt;
  assign err_cnt      = r_errCnt;
`else
  assign frame_ok_cnt = 16'd0;
  assign err_cnt      = 16'd0;
`endif

endmodule

// File: tb/tb_offchip_rx_deframer.sv
// Directed self-checking bench for offchip_rx_deframer: good, bad-CSUM,
// bad-LEN, junk, backpressure and mid-frame reset scenarios.
module tb_offchip_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_ok_cnt;
  logic [15:0] err_cnt;

  int checks     = 0;
  int failures   = 0;
  int cycle      = 0;
  int errPulses  = 0;
  int sentCount  = 0;
  bit senderDone = 1'b0;

  logic [7:0] rxData[$];
  logic       rxLast[$];
  int         rxCycle[$];
  logic [7:0] txQ[$];
  logic [7:0] expData[$];
  logic       expLast[$];

  offchip_rx_deframer #(
    .DEPTH(16),
    .MAX_LEN(8),
    .SOF_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .err_code(err_code),
    .frame_ok_cnt(frame_ok_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Inputs only change just after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rxData.push_back(out_data);
      rxLast.push_back(out_last);
      rxCycle.push_back(cycle);
    end
    if (frame_err) errPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt;
    waitCnt  = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitCnt < 500) begin
      waitCnt++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sentCount++;
  endtask

  task automatic sendBytes(input logic [7:0] q[$]);
    foreach (q[i]) begin
      applyStimulus(q[i]);
      idle(1);
    end
  endtask

  task automatic checkRx(input string tag);
    checkOutput($sformatf("%s_count", tag), rxData.size(), expData.size());
    for (int i = 0; i < expData.size() && i < rxData.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, rxData[i]}, {24'd0, expData[i]});
      checkOutput($sformatf("%s_last%0d", tag, i), {31'd0, rxLast[i]}, {31'd0, expLast[i]});
    end
    rxData.delete();
    rxLast.delete();
    rxCycle.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int errBase;
    int waitCnt;
    int sentBase;
    rst       = 1'b1;
    in_data   = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    $display("[TB] reset state");
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
    checkOutput("rst_ok_cnt", {16'd0, frame_ok_cnt}, 32'd0);
    checkOutput("rst_err_cnt", {16'd0, err_cnt}, 32'd0);

    $display("[TB] good frame");
    errBase = errPulses;
    txQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44};
    sendBytes(txQ);
    checkOutput("good_uncommitted_hidden", {31'd0, out_valid}, 32'd0);
    applyStimulus(8'h77);
    checkOutput("good_valid_after_csum", {31'd0, out_valid}, 32'd1);
    idle(6);
    if (rxCycle.size() == 3) begin
      checkOutput("good_consecutive1", rxCycle[1] - rxCycle[0], 32'd1);
      checkOutput("good_consecutive2", rxCycle[2] - rxCycle[1], 32'd1);
    end
    expData = '{8'h11, 8'h22, 8'h44};
    expLast = '{1'b0, 1'b0, 1'b1};
    checkRx("good");
    checkOutput("good_no_err", errPulses - errBase, 32'd0);

    $display("[TB] bad checksum");
    errBase = errPulses;
    txQ = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    sendBytes(txQ);
    idle(3);
    checkOutput("badcs_err_pulses", errPulses - errBase, 32'd1);
    checkOutput("badcs_err_code", {30'd0, err_code}, 32'd2);
    checkOutput("badcs_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("badcs_nothing_out", rxData.size(), 32'd0);
    txQ = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30};
    sendBytes(txQ);
    idle(5);
    expData = '{8'h10, 8'h20};
    expLast = '{1'b0, 1'b1};
    checkRx("after_badcs");

    $display("[TB] bad length");
    errBase = errPulses;
    txQ = '{8'hA5, 8'h00, 8'hA5, 8'h09};
    sendBytes(txQ);
    idle(3);
    checkOutput("badlen_err_pulses", errPulses - errBase, 32'd2);
    checkOutput("badlen_err_code", {30'd0, err_code}, 32'd1);
    checkOutput("badlen_out_valid", {31'd0, out_valid}, 32'd0);
    txQ = '{8'hA5, 8'h01, 8'h42, 8'h42};
    sendBytes(txQ);
    idle(4);
    expData = '{8'h42};
    expLast = '{1'b1};
    checkRx("after_badlen");

    $display("[TB] junk then frame");
    txQ = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h01, 8'h5A, 8'h5A};
    sendBytes(txQ);
    idle(4);
    expData = '{8'h5A};
    expLast = '{1'b1};
    checkRx("junk");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    txQ.delete();
    expData.delete();
    expLast.delete();
    for (int f = 1; f <= 3; f++) begin
      logic [7:0] cs;
      cs = 8'd0;
      txQ.push_back(8'hA5);
      txQ.push_back(8'h08);
      for (int i = 0; i < 8; i++) begin
        logic [7:0] b;
        b = 8'((f << 4) | (i + 1));
        cs ^= b;
        txQ.push_back(b);
        expData.push_back(b);
        expLast.push_back(i == 7);
      end
      txQ.push_back(cs);
    end
    sentBase   = sentCount;
    senderDone = 1'b0;
    fork
      begin
        sendBytes(txQ);
        senderDone = 1'b1;
      end
    join_none
    waitCnt = 0;
    @(negedge clk);
    while (!(in_valid && !in_ready) && waitCnt < 300) begin
      waitCnt++;
      @(negedge clk);
    end
    checkOutput("bp_stalled", {31'd0, in_valid && !in_ready}, 32'd1);
    checkOutput("bp_sent_at_stall", sentCount - sentBase, 32'd24);
    checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("bp_still_stalled", sentCount - sentBase, 32'd24);
    checkOutput("bp_nothing_popped", rxData.size(), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitCnt = 0;
    while (!senderDone && waitCnt < 500) begin
      waitCnt++;
      idle(1);
    end
    checkOutput("bp_sender_done", {31'd0, senderDone}, 32'd1);
    idle(30);
    checkRx("bp");

    $display("[TB] reset mid-frame");
    txQ = '{8'hA5, 8'h04, 8'h01};
    sendBytes(txQ);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_err_code", {30'd0, err_code}, 32'd0);
    checkOutput("midrst_ok_cnt", {16'd0, frame_ok_cnt}, 32'd0);
    txQ = '{8'hA5, 8'h01, 8'h77, 8'h77};
    sendBytes(txQ);
    idle(4);
    expData = '{8'h77};
    expLast = '{1'b1};
    checkRx("midrst");
`ifdef OFFCHIP_RX_STATS_EN
    checkOutput("midrst_ok_cnt_after", {16'd0, frame_ok_cnt}, 32'd1);
`else
    checkOutput("midrst_ok_cnt_after", {16'd0, frame_ok_cnt}, 32'd0);
`endif
    checkOutput("midrst_err_cnt_after", {16'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/offchip_rx_deframer.md
Name: offchip_rx_deframer

Overview:
- Downstream consumer of the off-chip link stage's reassembled byte stream (data/valid/ready, one byte per accepted transfer).
- Parses frames of the form SOF, LEN, LEN payload bytes, CSUM.
- Buffers payload in a byte FIFO and releases a frame to the core-side interface only after its checksum verifies. Frames that fail are rolled back and never reach the core.

Parameters:
- DEPTH, 16, payload FIFO entries; power of 2, at least 4.
- MAX_LEN, 8, largest legal LEN; must satisfy 1 <= MAX_LEN <= DEPTH.
- SOF_BYTE, 8'hA5, start-of-frame delimiter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- in_data, input, 8, byte from the link stage.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, deframer can accept a byte; the link stage is backpressured by this.
- out_data, output, 8, payload byte to the core.
- out_last, output, 1, out_data is the final byte of its frame.
- out_valid, output, 1, committed payload is available.
- out_ready, input, 1, core accepts out_data.
- frame_err, output, 1, one-cycle error pulse.
- err_code, output, 2, error cause: 1 = bad LEN, 2 = bad CSUM; holds its last value.
- frame_ok_cnt, output, 16, frames committed (optional feature).
- err_cnt, output, 16, frames discarded (optional feature).

Behaviour:
- Input transfer: occurs when in_valid && in_ready on a rising clk edge. The upstream drops valid the cycle after a transfer.
- Pointers: wptr, cptr (commit) and rptr, each log2(DEPTH)+1 bits, wrapping naturally.
  - used = wptr - rptr.
  - full = (used == DEPTH).
- Memory: each entry is 9 bits, {last, byte}. Read is combinational at rptr.
- State machine: HUNT, LEN, PAY, CSUM.
- HUNT: in_ready = 1.
  - An accepted byte equal to SOF_BYTE goes to LEN.
  - Any other byte is silently dropped.
- LEN: in_ready = 1.
  - Accepted N with 1 <= N <= MAX_LEN: load remaining count rem = N, clear csum to 0, go to PAY.
  - Otherwise: frame_err = 1 next cycle, err_code = 1, go to HUNT.
- PAY: in_ready = !full.
  - Each accepted byte is written at wptr with last = (rem == 1); then wptr++, rem--, csum ^= byte.
  - Go to CSUM after the byte with rem == 1.
- CSUM: in_ready = 1.
  - Accepted byte == csum: cptr <= wptr (frame committed), go to HUNT.
  - Mismatch: wptr <= cptr (rollback), frame_err pulse, err_code = 2, go to HUNT.
- SOF_BYTE seen inside PAY or CSUM is treated as data; there is no resync mid-frame.
- Output side:
  - out_valid = (cptr != rptr); uncommitted bytes are never visible.
  - out_data and out_last come from mem[rptr].
  - Pop on out_valid && out_ready: rptr++.
- Latency: the first payload byte is presented the cycle after the CSUM byte is accepted.
- Deadlock freedom: MAX_LEN <= DEPTH guarantees that draining committed data always frees enough space to finish the frame.
- Simultaneous events:
  - Pop in the same cycle as a commit or rollback is legal. rptr updates independently, and full is evaluated on pre-edge values.
  - A commit never moves cptr past wptr.
- Reset values, taking effect at any time including mid-frame:
  - state = HUNT; wptr = cptr = rptr = 0.
  - in_ready = 1, out_valid = 0, frame_err = 0, err_code = 0, counters = 0.
  - FIFO contents need not be cleared. Any partial frame is lost.

Optional Feature:
- Macro: OFFCHIP_RX_STATS_EN.
- Defined:
  - frame_ok_cnt increments on each commit.
  - err_cnt increments on each frame_err.
  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Good frame: A5, 03, 11, 22, 44, CSUM 77 with out_ready = 1.
  - out_valid rises the cycle after 77 is accepted.
  - Core receives 11, 22, 44 on consecutive cycles, out_last only on 44.
  - frame_err stays 0.
- Bad checksum: A5, 02, 10, 20, then 31.
  - frame_err pulses once, err_code = 2.
  - out_valid never rises; wptr returns to cptr.
  - A following good frame is delivered intact.
- Bad length: A5, 00, then A5, 09 with MAX_LEN = 8.
  - Two frame_err pulses, err_code = 1.
  - The machine returns to HUNT each time.
- Junk then frame: 00, FF, 3C, A5, 01, 5A, 5A.
  - Junk bytes are dropped; exactly one byte 5A with out_last = 1 is delivered.
- Backpressure, DEPTH = 16, out_ready = 0: send three 8-byte good frames.
  - in_ready drops after 16 stored bytes, in the middle of the third frame.
  - Raising out_ready drains frame 1 and resumes intake.
  - All 24 bytes are delivered in order.
- Reset mid-frame after A5, 04, 01: assert rst for one cycle.
  - out_valid = 0, state = HUNT.
  - The next good frame is delivered.
  - With OFFCHIP_RX_STATS_EN defined, frame_ok_cnt = 1 after that frame.
